// File: rtl/seg7_pkg.sv
// Shared 7-segment types and active-low {g,f,e,d,c,b,a} patterns for the
// BCD display designs.
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  // Non-decimal nibbles are forced to zero so the counter only holds valid BCD.
  function automatic bcd_t bcd_sanitize(input bcd_t d);
    if (d > 4'd9) begin
      return 4'd0;
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes blank
// the digit.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg
);

  // Digit pattern lookup.
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// N-digit BCD up/down counter with scanned common-anode 7-segment output.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bcd_scan_counter
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    cnt_en,
  input  logic                    up_down,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    wrap,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [4*NUM_DIGITS-1:0] count_r;
  logic [4*NUM_DIGITS-1:0] count_next_s;
  logic                    wrap_r;
  logic                    wrap_next_s;
  logic                    carry_s;
  logic [DIV_W-1:0]        div_r;
  logic [IDX_W-1:0]        idx_r;
  logic [6:0]              seg_r;
  logic [NUM_DIGITS-1:0]   an_r;
  bcd_t                    digits_s [NUM_DIGITS];
  bcd_t                    digit_s;
  bcd_t                    disp_bcd_s;
  logic [6:0]              seg_dec_s;

  // Next count: load beats counting; the carry/borrow ripples from digit 0 upward.
  always_comb begin
    count_next_s = count_r;
    wrap_next_s  = 1'b0;
    carry_s      = 1'b1;
    if (load) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        count_next_s[4*i +: 4] = bcd_sanitize(load_value[4*i +: 4]);
      end
    end else if (cnt_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (!carry_s) begin
          count_next_s[4*i +: 4] = count_r[4*i +: 4];
        end else if (up_down) begin
          if (count_r[4*i +: 4] == 4'd9) begin
            count_next_s[4*i +: 4] = 4'd0;
          end else begin
            count_next_s[4*i +: 4] = count_r[4*i +: 4] + 4'd1;
            carry_s = 1'b0;
          end
        end else begin
          if (count_r[4*i +: 4] == 4'd0) begin
            count_next_s[4*i +: 4] = 4'd9;
          end else begin
            count_next_s[4*i +: 4] = count_r[4*i +: 4] - 4'd1;
            carry_s = 1'b0;
          end
        end
      end
      wrap_next_s = carry_s;
    end else begin
      count_next_s = count_r;
    end
  end

  // Counter and wrap pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= {(4*NUM_DIGITS){1'b0}};
      wrap_r  <= 1'b0;
    end else begin
      count_r <= count_next_s;
      wrap_r  <= wrap_next_s;
    end
  end

  // Refresh divider and digit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_r <= {DIV_W{1'b0}};
      idx_r <= {IDX_W{1'b0}};
    end else if (div_r == DIV_LAST) begin
      div_r <= {DIV_W{1'b0}};
      if (idx_r == IDX_LAST) begin
        idx_r <= {IDX_W{1'b0}};
      end else begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end else begin
      div_r <= div_r + DIV_W'(1);
      idx_r <= idx_r;
    end
  end

  // Digit mux; a leading-zero digit is replaced by a non-decimal code that decodes to blank.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digits_s[i] = count_r[4*i +: 4];
    end
    digit_s = digits_s[idx_r];
`ifdef LEADING_ZERO_BLANK_EN
    begin : lz_blk
      logic [NUM_DIGITS-1:0] lz_s;
      lz_s = {NUM_DIGITS{1'b0}};
      lz_s[NUM_DIGITS-1] = (digits_s[NUM_DIGITS-1] == 4'd0);
      for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
        lz_s[i] = lz_s[i+1] & (digits_s[i] == 4'd0);
      end
      if ((idx_r != {IDX_W{1'b0}}) && lz_s[idx_r]) begin
        disp_bcd_s = 4'hF;
      end else begin
        disp_bcd_s = digit_s;
      end
    end
`else
    disp_bcd_s = digit_s;
`endif
  end

  bcd_to_seg7 u_dec (
    .bcd (disp_bcd_s),
    .seg (seg_dec_s)
  );

  // Registered display drive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_r <= SEG_BLANK;
      an_r  <= {NUM_DIGITS{1'b1}};
    end else begin
      seg_r <= seg_dec_s;
      if (enable) begin
        an_r <= ~(NUM_DIGITS'(1) << idx_r);
      end else begin
        an_r <= {NUM_DIGITS{1'b1}};
      end
    end
  end

  assign count_bcd = count_r;
  assign wrap      = wrap_r;
  assign seg       = seg_r;
  assign an        = an_r;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench for bcd_scan_counter (4 digits, 4-cycle refresh slot)
// against an integer-arithmetic reference model.
module tb_bcd_scan_counter;

  localparam int ND = 4;
  localparam int SD = 4;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          cnt_en;
  logic          up_down;
  logic          load;
  logic [15:0]   load_value;
  logic [15:0]   count_bcd;
  logic          wrap;
  logic [6:0]    seg;
  logic [ND-1:0] an;

  int total = 0;
  int bad   = 0;
  int cnt_m = 0;
  int k     = 0;
  logic wrap_m = 1'b0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  bcd_scan_counter #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .cnt_en     (cnt_en),
    .up_down    (up_down),
    .load       (load),
    .load_value (load_value),
    .count_bcd  (count_bcd),
    .wrap       (wrap),
    .seg        (seg),
    .an         (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = 16'h0000;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int from_load(input logic [15:0] lv);
    int v;
    int p;
    int d;
    v = 0;
    p = 1;
    for (int i = 0; i < ND; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 0;
      v = v + d * p;
      p = p * 10;
    end
    return v;
  endfunction

  function automatic logic [6:0] exp_seg(input int cnt, input int idx);
    int p;
    p = 10 ** idx;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && cnt < p) return 7'h7F;
`endif
    return seg_tab[(cnt / p) % 10];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_count"}, 32'(count_bcd), 32'h0);
    check({tag, "_wrap"},  32'(wrap), 32'h0);
    check({tag, "_seg"},   32'(seg), 32'h7F);
    check({tag, "_an"},    32'(an), 32'hF);
  endtask

  // One clock edge with the given inputs; expectations come from the model.
  task automatic step(input logic ld, input logic [15:0] lv, input logic ce,
                      input logic ud, input logic en);
    int idx;
    logic [6:0] es;
    logic [ND-1:0] ea;
    load = ld; load_value = lv; cnt_en = ce; up_down = ud; enable = en;
    idx = (k / SD) % ND;
    es  = exp_seg(cnt_m, idx);
    ea  = en ? ~(4'b0001 << idx) : 4'hF;
    if (ld) begin
      cnt_m = from_load(lv); wrap_m = 1'b0;
    end else if (ce && ud) begin
      wrap_m = (cnt_m == 9999); cnt_m = (cnt_m + 1) % 10000;
    end else if (ce) begin
      wrap_m = (cnt_m == 0); cnt_m = (cnt_m + 9999) % 10000;
    end else begin
      wrap_m = 1'b0;
    end
    k++;
    @(posedge clk);
    #1;
    check("count", 32'(count_bcd), 32'(to_bcd(cnt_m)));
    check("wrap",  32'(wrap), 32'(wrap_m));
    check("seg",   32'(seg), 32'(es));
    check("an",    32'(an), 32'(ea));
  endtask

  task automatic hold(input int n, input logic en);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0, 1'b1, en);
  endtask

  initial begin
    logic ld;
    logic [15:0] lv;
    rst = 1'b0; enable = 1'b1; cnt_en = 1'b0; up_down = 1'b1;
    load = 1'b0; load_value = 16'h0000;
    #12;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b1; k = 0; cnt_m = 0;

    // Up wrap
    step(1'b1, 16'h9998, 1'b0, 1'b1, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    check("up_9999", 32'(count_bcd), 32'h9999);
    step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    check("up_wrap_cnt", 32'(count_bcd), 32'h0000);
    check("up_wrap_pulse", 32'(wrap), 32'h1);
    hold(1, 1'b1);
    check("wrap_one_cycle", 32'(wrap), 32'h0);

    // Down borrow and underflow
    step(1'b1, 16'h1000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    check("borrow", 32'(count_bcd), 32'h0999);
    step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    check("underflow", 32'(count_bcd), 32'h9999);
    check("underflow_pulse", 32'(wrap), 32'h1);

    // Load precedence and sanitising
    step(1'b1, 16'h12A4, 1'b1, 1'b1, 1'b1);
    check("load_sanitise", 32'(count_bcd), 32'h1204);
    check("load_no_wrap", 32'(wrap), 32'h0);

    // Scan, then blanked display
    step(1'b1, 16'h1234, 1'b0, 1'b1, 1'b1);
    hold(20, 1'b1);
    hold(8, 1'b0);
    check("blank_keeps_count", 32'(count_bcd), 32'h1234);

    // Leading zeros
    step(1'b1, 16'h0070, 1'b0, 1'b1, 1'b1);
    hold(20, 1'b1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      ld = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 2))
        0:       lv = 16'h9996;
        1:       lv = 16'h0003;
        default: lv = 16'($urandom);
      endcase
      step(ld, lv, ($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 7) != 0));
    end

    // Asynchronous reset mid-frame
    step(1'b1, 16'h5678, 1'b0, 1'b1, 1'b1);
    hold(5, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    check_reset("async_reset");
    #1;
    rst = 1'b1; k = 0; cnt_m = 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 16'h0000, 1'($urandom), 1'($urandom), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
